// File: rtl/rob_multi_pkg.sv
// Shared defaults for the reorder buffer slice.
// Sizing knobs for depth, lane counts and register index width.
package rob_multi_pkg;

  localparam int DEF_ENT_NUM   = 64;
  localparam int DEF_ENT_SEL   = 6;
  localparam int DEF_DP_WIDTH  = 2;
  localparam int DEF_COM_WIDTH = 2;
  localparam int DEF_FIN_PORTS = 4;
  localparam int DEF_ARF_SEL   = 5;

endpackage

// File: rtl/rob_com_sel.sv
// Commit lane selector: prefix-valid mask over ready lanes.
// A store ends the run so at most one store retires per cycle.
module rob_com_sel #(
  parameter int COM_WIDTH = 2,
  parameter int NUM_W     = 2
) (
  input  logic [COM_WIDTH-1:0] i_rdy,
  input  logic [COM_WIDTH-1:0] i_st,
  output logic [COM_WIDTH-1:0] o_vld,
  output logic [NUM_W-1:0]     o_num
);

  logic w_blk;

  always_comb begin
    w_blk = 1'b0;
    o_vld = '0;
    o_num = '0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      o_vld[k] = i_rdy[k] & ~w_blk;
      o_num    = o_num + NUM_W'(o_vld[k]);
      w_blk    = w_blk | ~i_rdy[k] | i_st[k];
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Multi-lane reorder buffer: in-order allocate and commit,
// out-of-order finish, full pipeline flush.
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int ENT_NUM   = DEF_ENT_NUM,
  parameter int ENT_SEL   = DEF_ENT_SEL,
  parameter int DP_WIDTH  = DEF_DP_WIDTH,
  parameter int COM_WIDTH = DEF_COM_WIDTH,
  parameter int FIN_PORTS = DEF_FIN_PORTS,
  parameter int ARF_SEL   = DEF_ARF_SEL
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DP_WIDTH-1:0]            i_dp_vld,
  input  logic [DP_WIDTH-1:0]            i_dp_rd_wr_en,
  input  logic [DP_WIDTH*ARF_SEL-1:0]    i_dp_rd_wr_addr,
  input  logic [DP_WIDTH-1:0]            i_dp_is_st,
  output logic                           o_dp_rdy,
  output logic [DP_WIDTH*ENT_SEL-1:0]    o_dp_ptr,
  input  logic [FIN_PORTS-1:0]           i_fin_vld,
  input  logic [FIN_PORTS*ENT_SEL-1:0]   i_fin_tag,
  input  logic                           i_flush,
  output logic [COM_WIDTH-1:0]           o_com_vld,
  output logic [COM_WIDTH*ENT_SEL-1:0]   o_com_ptr,
  output logic [COM_WIDTH-1:0]           o_com_rd_wr_en,
  output logic [COM_WIDTH*ARF_SEL-1:0]   o_com_rd_wr_addr,
  output logic [$clog2(COM_WIDTH+1)-1:0] o_com_num,
  output logic                           o_com_stbuf,
  output logic [ENT_SEL:0]               o_cnt,
  output logic                           o_empty
);

  localparam int NUM_W = $clog2(COM_WIDTH+1);

  logic [ENT_SEL-1:0] r_head;
  logic [ENT_SEL-1:0] r_tail;
  logic [ENT_SEL:0]   r_cnt;
  logic [ENT_NUM-1:0] r_vld;
  logic [ENT_NUM-1:0] r_fin;
  logic [ENT_NUM-1:0] r_wen;
  logic [ENT_NUM-1:0] r_st;
  logic [ARF_SEL-1:0] r_addr [ENT_NUM];

  logic [ENT_NUM-1:0]   w_vld_n;
  logic [ENT_NUM-1:0]   w_fin_n;
  logic [ENT_SEL-1:0]   w_dp_ptr [DP_WIDTH];
  logic [ENT_SEL-1:0]   w_com_ptr [COM_WIDTH];
  logic [ENT_SEL:0]     w_dp_num;
  logic                 w_dp_acc;
  logic [COM_WIDTH-1:0] w_rdy;
  logic [COM_WIDTH-1:0] w_cst;
  logic [COM_WIDTH-1:0] w_com_vld;
  logic [NUM_W-1:0]     w_com_num;
  logic [ENT_SEL-1:0]   w_tag;

  assign o_dp_rdy = r_cnt <= (ENT_SEL+1)'(ENT_NUM - DP_WIDTH);
  assign w_dp_acc = o_dp_rdy & ~i_flush;
  assign o_cnt    = r_cnt;
  assign o_empty  = r_cnt == '0;

  always_comb begin
    w_dp_num = '0;
    o_dp_ptr = '0;
    for (int k = 0; k < DP_WIDTH; k++) begin
      w_dp_ptr[k] = r_tail + ENT_SEL'(k);
      w_dp_num    = w_dp_num + (ENT_SEL+1)'(i_dp_vld[k]);
      o_dp_ptr[k*ENT_SEL +: ENT_SEL] = w_dp_ptr[k];
    end
  end

  always_comb begin
    o_com_ptr        = '0;
    o_com_rd_wr_en   = '0;
    o_com_rd_wr_addr = '0;
    w_rdy            = '0;
    w_cst            = '0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      w_com_ptr[k] = r_head + ENT_SEL'(k);
      w_rdy[k] = r_vld[w_com_ptr[k]] & r_fin[w_com_ptr[k]];
      w_cst[k] = r_st[w_com_ptr[k]];
      o_com_rd_wr_en[k] = r_wen[w_com_ptr[k]];
      o_com_ptr[k*ENT_SEL +: ENT_SEL] = w_com_ptr[k];
      o_com_rd_wr_addr[k*ARF_SEL +: ARF_SEL] = r_addr[w_com_ptr[k]];
    end
  end

  rob_com_sel #(
    .COM_WIDTH (COM_WIDTH),
    .NUM_W     (NUM_W)
  ) u_com_sel (
    .i_rdy (w_rdy),
    .i_st  (w_cst),
    .o_vld (w_com_vld),
    .o_num (w_com_num)
  );

  assign o_com_vld   = w_com_vld;
  assign o_com_num   = w_com_num;
  assign o_com_stbuf = |(w_com_vld & w_cst);

  // Dispatch is applied last so it overrides a same-tag finish.
  always_comb begin
    w_vld_n = r_vld;
    w_fin_n = r_fin;
    w_tag   = '0;
    for (int p = 0; p < FIN_PORTS; p++) begin
      w_tag = i_fin_tag[p*ENT_SEL +: ENT_SEL];
      if (i_fin_vld[p] && r_vld[w_tag])
        w_fin_n[w_tag] = 1'b1;
    end
    for (int k = 0; k < COM_WIDTH; k++) begin
      if (w_com_vld[k]) begin
        w_vld_n[w_com_ptr[k]] = 1'b0;
        w_fin_n[w_com_ptr[k]] = 1'b0;
      end
    end
    if (i_flush) begin
      w_vld_n = '0;
      w_fin_n = '0;
    end else if (w_dp_acc) begin
      for (int k = 0; k < DP_WIDTH; k++) begin
        if (i_dp_vld[k]) begin
          w_vld_n[w_dp_ptr[k]] = 1'b1;
          w_fin_n[w_dp_ptr[k]] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
      r_fin  <= '0;
    end else begin
      r_vld <= w_vld_n;
      r_fin <= w_fin_n;
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
        r_cnt  <= '0;
      end else begin
        r_head <= r_head + ENT_SEL'(w_com_num);
        if (w_dp_acc)
          r_tail <= r_tail + w_dp_num[ENT_SEL-1:0];
        r_cnt <= r_cnt + (w_dp_acc ? w_dp_num : '0)
               - (ENT_SEL+1)'(w_com_num);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_dp_acc) begin
      for (int k = 0; k < DP_WIDTH; k++) begin
        if (i_dp_vld[k]) begin
          r_wen[w_dp_ptr[k]]  <= i_dp_rd_wr_en[k];
          r_st[w_dp_ptr[k]]   <= i_dp_is_st[k];
          r_addr[w_dp_ptr[k]] <= i_dp_rd_wr_addr[k*ARF_SEL +: ARF_SEL];
        end
      end
    end
  end

endmodule
